// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID pipeline register,
// and saturating stall/flush debug counters.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PC_IFWrite,
  input  logic        Branch_taken,
  input  logic [31:0] BranchAddr,
  input  logic        Jump,
  input  logic [31:0] JumpAddr,
  input  logic        IF_flush,
  output logic [31:0] IMemAddr,
  input  logic [31:0] IMemData,
  output logic [31:0] PC,
  output logic [31:0] PC_id,
  output logic [31:0] Instruction_id,
  output logic        Valid_id,
  output logic [15:0] StallCnt,
  output logic [15:0] FlushCnt
);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  function automatic logic [15:0] satInc(input logic [15:0] cnt);
    return (cnt == CNT_MAX) ? cnt : cnt + 16'd1;
  endfunction

  logic        redir;
  logic [31:0] targetSel;
  logic [31:0] redirTarget;
  logic [31:0] pcPlus4;

  // Branch wins over jump; targets are always word aligned.
  assign redir       = Branch_taken | Jump;
  assign targetSel   = Branch_taken ? BranchAddr : JumpAddr;
  assign redirTarget = targetSel & 32'hFFFF_FFFC;
  assign pcPlus4     = PC + 32'd4;
  assign IMemAddr    = PC;

  // ---- PC / IF-ID boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      PC             <= RESET_PC;
      Instruction_id <= NOP_INSTR;
      PC_id          <= 32'd0;
      Valid_id       <= 1'b0;
      StallCnt       <= 16'd0;
      FlushCnt       <= 16'd0;
    end else if (redir) begin
      PC             <= redirTarget;
      Instruction_id <= NOP_INSTR;
      PC_id          <= 32'd0;
      Valid_id       <= 1'b0;
      FlushCnt       <= satInc(FlushCnt);
    end else if (IF_flush) begin
      if (PC_IFWrite) PC <= pcPlus4;
      Instruction_id <= NOP_INSTR;
      PC_id          <= 32'd0;
      Valid_id       <= 1'b0;
      FlushCnt       <= satInc(FlushCnt);
    end else if (!PC_IFWrite) begin
      StallCnt       <= satInc(StallCnt);
    end else begin
      PC             <= pcPlus4;
      Instruction_id <= IMemData;
      PC_id          <= pcPlus4;
      Valid_id       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Randomized and directed bench for if_stage, checked against a behavioural
// model of the fetch stage built from the stage's priority rules.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PC_IFWrite = 1'b1;
  logic        Branch_taken = 1'b0;
  logic [31:0] BranchAddr = 32'd0;
  logic        Jump = 1'b0;
  logic [31:0] JumpAddr = 32'd0;
  logic        IF_flush = 1'b0;
  logic [31:0] IMemAddr;
  logic [31:0] IMemData;
  logic [31:0] PC;
  logic [31:0] PC_id;
  logic [31:0] Instruction_id;
  logic        Valid_id;
  logic [15:0] StallCnt;
  logic [15:0] FlushCnt;

  int nChecks = 0;
  int nPass   = 0;

  // Reference state
  logic [31:0] mPC, mPCid, mInstr;
  logic        mValid;
  int          mStall, mFlush;

  if_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .PC_IFWrite(PC_IFWrite),
    .Branch_taken(Branch_taken), .BranchAddr(BranchAddr),
    .Jump(Jump), .JumpAddr(JumpAddr), .IF_flush(IF_flush),
    .IMemAddr(IMemAddr), .IMemData(IMemData), .PC(PC), .PC_id(PC_id),
    .Instruction_id(Instruction_id), .Valid_id(Valid_id),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return 32'h1000_0000 + addr;
  endfunction

  // Instruction memory: combinational read
  assign IMemData = memWord(IMemAddr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic int satAdd(input int c);
    return (c >= 65535) ? 65535 : c + 1;
  endfunction

  task automatic bubble();
    mInstr = NOP; mPCid = 32'd0; mValid = 1'b0;
  endtask

  // Advance the model by one edge using the currently driven inputs.
  task automatic modelEdge();
    if (rst) begin
      mPC = 32'd0; bubble(); mStall = 0; mFlush = 0;
    end else if (Branch_taken || Jump) begin
      mPC = (Branch_taken ? BranchAddr : JumpAddr) / 4 * 4;
      bubble(); mFlush = satAdd(mFlush);
    end else if (IF_flush) begin
      if (PC_IFWrite) mPC = mPC + 32'd4;
      bubble(); mFlush = satAdd(mFlush);
    end else if (!PC_IFWrite) begin
      mStall = satAdd(mStall);
    end else begin
      mInstr = memWord(mPC);
      mPC = mPC + 32'd4;
      mPCid = mPC;
      mValid = 1'b1;
    end
  endtask

  task automatic step(input bit doChk);
    modelEdge();
    @(posedge clk);
    #1;
    if (doChk) begin
      chk("PC", PC, mPC);
      chk("IMemAddr", IMemAddr, mPC);
      chk("PC_id", PC_id, mPCid);
      chk("Instruction_id", Instruction_id, mInstr);
      chk("Valid_id", {31'd0, Valid_id}, {31'd0, mValid});
      chk("StallCnt", {16'd0, StallCnt}, mStall);
      chk("FlushCnt", {16'd0, FlushCnt}, mFlush);
    end
  endtask

  task automatic idle();
    Branch_taken = 1'b0; Jump = 1'b0; IF_flush = 1'b0; PC_IFWrite = 1'b1;
  endtask

  initial begin
    // Reset then run
    #1;
    step(1); step(1);
    chk("reset_pc", PC, 32'h0);
    chk("reset_valid", {31'd0, Valid_id}, 32'd0);
    chk("reset_instr", Instruction_id, NOP);
    rst = 1'b0;
    step(1);
    chk("run_pc4", PC, 32'h4);
    chk("run_instr0", Instruction_id, 32'h1000_0000);
    chk("run_pcid4", PC_id, 32'h4);
    chk("run_valid", {31'd0, Valid_id}, 32'd1);
    step(1);
    chk("run_pc8", PC, 32'h8);
    step(1); step(1);
    chk("run_pc10", PC, 32'h10);

    // Load-use stall for three cycles
    PC_IFWrite = 1'b0;
    for (int i = 0; i < 3; i++) step(1);
    chk("stall_pc", PC, 32'h10);
    chk("stall_instr_hold", Instruction_id, 32'h1000_000C);
    chk("stall_cnt3", {16'd0, StallCnt}, 32'd3);
    PC_IFWrite = 1'b1;
    step(1);
    chk("resume_pc", PC, 32'h14);
    chk("resume_instr", Instruction_id, 32'h1000_0010);

    // Branch redirect with misaligned target
    Branch_taken = 1'b1; BranchAddr = 32'h0000_0103;
    step(1);
    chk("br_pc", PC, 32'h100);
    chk("br_valid", {31'd0, Valid_id}, 32'd0);
    chk("br_instr", Instruction_id, NOP);
    chk("br_flushcnt", {16'd0, FlushCnt}, 32'd1);
    idle();
    step(1);
    chk("br_fetch_target", Instruction_id, 32'h1000_0100);

    // Redirect during stall, then branch+jump together
    PC_IFWrite = 1'b0; Jump = 1'b1; JumpAddr = 32'h200;
    step(1);
    chk("jmp_stall_pc", PC, 32'h200);
    chk("jmp_stall_cnt", {16'd0, StallCnt}, 32'd3);
    Branch_taken = 1'b1; BranchAddr = 32'h300;
    step(1);
    chk("br_wins_pc", PC, 32'h300);
    idle();
    step(1);

    // IF_flush with and without PC_IFWrite
    IF_flush = 1'b1;
    step(1);
    PC_IFWrite = 1'b0;
    step(1);
    idle();
    step(1);

    // PC wrap
    Jump = 1'b1; JumpAddr = 32'hFFFF_FFFC;
    step(1);
    idle();
    step(1);
    chk("wrap_pc", PC, 32'h0);
    chk("wrap_instr", Instruction_id, 32'h0FFF_FFFC);
    chk("wrap_pcid", PC_id, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst          = ($urandom_range(0, 49) == 0);
      PC_IFWrite   = ($urandom_range(0, 3) != 0);
      Branch_taken = ($urandom_range(0, 9) == 0);
      Jump         = ($urandom_range(0, 9) == 0);
      IF_flush     = ($urandom_range(0, 19) == 0);
      BranchAddr   = $urandom;
      JumpAddr     = $urandom;
      step(1);
    end
    rst = 1'b0; idle();

    // Reset mid-stall
    rst = 1'b1; step(1);
    rst = 1'b0; PC_IFWrite = 1'b0;
    for (int i = 0; i < 5; i++) step(1);
    chk("pre_rst_stall5", {16'd0, StallCnt}, 32'd5);
    rst = 1'b1; Jump = 1'b1; JumpAddr = 32'h400;
    step(1);
    chk("rst_mid_stall_cnt", {16'd0, StallCnt}, 32'd0);
    chk("rst_mid_flush_cnt", {16'd0, FlushCnt}, 32'd0);
    chk("rst_mid_pc", PC, 32'h0);
    Jump = 1'b0;

    // Stall counter saturation
    rst = 1'b0; PC_IFWrite = 1'b0;
    for (int i = 0; i < 65540; i++) step(0);
    step(1);
    chk("stall_sat", {16'd0, StallCnt}, 32'h0000_FFFF);
    PC_IFWrite = 1'b1;
    step(1);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
